// File: rtl/fifo_write_scheduler.sv
// fifo_write_scheduler: arbitrates NUM_REQ requesters onto one FIFO write
// port. Round-robin owner selection with bursts of up to BURST_LEN words,
// zero-latency combinational grant, and an accepted-word counter.
module fifo_write_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_in,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [NUM_REQ*WIDTH-1:0]   data_in,
    input  logic                       full_in,
    output logic [NUM_REQ-1:0]         grant_out,
    output logic                       write_out,
    output logic [WIDTH-1:0]           data_write_out,
    output logic [$clog2(NUM_REQ)-1:0] owner_out,
    output logic                       busy_out,
    output logic [15:0]                words_written_out
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [OW:0]   NREQ_W  = (OW+1)'(NUM_REQ);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [15:0]   words_q, words_d;

    logic [NUM_REQ-1:0] grant;
    logic [OW-1:0]      cand;
    logic               cand_vld;

    // Pointer to the requester after p, wrapping at NUM_REQ.
    function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] p);
        logic [OW:0] s;
        s = {1'b0, p} + (OW+1)'(1);
        if (s >= NREQ_W) s = '0;
        return s[OW-1:0];
    endfunction

    // Round-robin candidate: first active request at rr_ptr, rr_ptr+1, ...
    // Scanning offsets downward lets the smallest offset win.
    always_comb begin
        logic [OW:0] idx;
        cand     = '0;
        cand_vld = 1'b0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (OW+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (req_in[idx[OW-1:0]]) begin
                cand     = idx[OW-1:0];
                cand_vld = 1'b1;
            end
        end
    end

    // Next-state and grant decision; reset suppresses any grant.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant       = '0;
        if (!sys_rst_in) begin
            case (state_q)
                IDLE: begin
                    // Ownership is never taken while the FIFO is full.
                    if (cand_vld && !full_in) begin
                        grant[cand] = 1'b1;
                        if (BURST_LEN == 1) begin
                            rr_ptr_d = next_ptr(cand);
                        end else begin
                            state_d     = OWN;
                            owner_d     = cand;
                            burst_cnt_d = CW'(1);
                        end
                    end
                end
                OWN: begin
                    if (!req_in[owner_q]) begin
                        // Owner released early: one bubble, then re-arbitrate.
                        rr_ptr_d    = next_ptr(owner_q);
                        burst_cnt_d = '0;
                        state_d     = IDLE;
                    end else if (!full_in) begin
                        grant[owner_q] = 1'b1;
                        if (burst_cnt_q == LAST_CNT) begin
                            burst_cnt_d = '0;
                            rr_ptr_d    = next_ptr(owner_q);
                            state_d     = IDLE;
                        end else begin
                            burst_cnt_d = burst_cnt_q + CW'(1);
                        end
                    end
                    // full_in with request held: stall, everything holds.
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Write port mux: granted requester's slice, zero when idle.
    always_comb begin
        data_write_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) data_write_out = data_in[i*WIDTH +: WIDTH];
        end
    end

    // Accepted-word counter wraps naturally at 16 bits.
    always_comb begin
        words_d = words_q + {15'd0, |grant};
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_in) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            words_q     <= words_d;
        end
    end

    assign grant_out         = grant;
    assign write_out         = |grant;
    assign owner_out         = (!sys_rst_in && state_q == OWN) ? owner_q : '0;
    assign busy_out          = !sys_rst_in && (state_q == OWN);
    assign words_written_out = words_q;

endmodule
